// File: rtl/spi_config_loader_pkg.sv
// Shared definitions for the SPI configuration loader and the network core it
// feeds: frame field positions, FSM state encoding and parameter-file defaults.
package spi_config_loader_pkg;

  // 16-bit frame: [15] R/W (1 = read), [14:12] reserved, [11:8] addr, [7:0] data
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Parameter register-file shape, shared with the spiking-network core
  localparam int         NUM_REGS_DEF      = 15;
  localparam logic [7:0] THRESHOLD_RST_DEF = 8'd255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    COMMIT  = 2'd2,
    WAIT_CS = 2'd3
  } cfg_state_e;

  // True when addr names an implemented parameter register
  function automatic logic addr_in_range(input logic [3:0] addr,
                                         input logic [4:0] num_regs);
    return ({1'b0, addr} < num_regs);
  endfunction

endpackage

// File: rtl/spi_config_loader_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin, with single-cycle rise and
// fall pulses derived from the synchronized level.
//   clk, rst_n : system clock, asynchronous active-low reset
//   async_in   : asynchronous input pin
//   sync_out   : synchronized level (STAGES cycles of latency)
//   rise, fall : one-cycle pulses on synchronized edges
module spi_config_loader_sync_edge_detect #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule

// File: rtl/spi_config_loader.sv
// SPI mode-0 configuration front end for the spiking-network core. Receives
// 16-bit frames, issues single-cycle parameter writes and keeps a shadow copy
// of every parameter byte so the host can read values back over MISO.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi: asynchronous SPI inputs (sclk idles low)
//   spi_miso          : read data, driven only during bits 8..15 of read frames
//   cfg_addr/cfg_data : register-file write address/data (held between writes)
//   cfg_write_enable  : one-cycle write strobe
//   busy              : frame in progress (SHIFT or COMMIT)
//   frame_error       : one-cycle pulse on an aborted or out-of-range write
module spi_config_loader
  import spi_config_loader_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter int         NUM_REGS      = NUM_REGS_DEF,
  parameter logic [7:0] THRESHOLD_RST = THRESHOLD_RST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [3:0] cfg_addr,
  output logic [7:0] cfg_data,
  output logic       cfg_write_enable,
  output logic       busy,
  output logic       frame_error
);

  localparam logic [4:0] NREGS = NUM_REGS[4:0];
  // Header byte is complete after 8 bits; its fields sit 8 positions lower then
  localparam int HDR_SHIFT = 8;

  cfg_state_e state, state_nxt;

  logic                   sclk_lvl_unused, sclk_rise, sclk_fall;
  logic                   cs_n_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   mosi_s;

  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic [15:0] frame_nxt;
  logic [7:0]  tx_reg;
  logic        rd_frame;
  logic [7:0]  shadow [NUM_REGS];

  logic        shift_evt, last_bit;
  logic [3:0]  hdr_addr;
  logic        commit_addr_ok;

  spi_config_loader_sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (spi_sclk),
    .sync_out (sclk_lvl_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_config_loader_sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (spi_cs_n),
    .sync_out (cs_n_s),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // mosi only needs a level; it is sampled on the synced sclk rise, and since
  // it shares the sclk synchronizer depth it is stable by then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_chain <= '0;
    else        mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  assign frame_nxt      = {shift_reg[14:0], mosi_s};
  assign shift_evt      = (state == SHIFT) && sclk_rise;
  assign last_bit       = shift_evt && (bit_cnt == 5'd15);
  assign hdr_addr       = frame_nxt[ADDR_MSB-HDR_SHIFT:ADDR_LSB-HDR_SHIFT];
  assign commit_addr_ok = addr_in_range(shift_reg[ADDR_MSB:ADDR_LSB], NREGS);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and strobes
  always_comb begin
    state_nxt        = state;
    cfg_write_enable = 1'b0;
    frame_error      = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = SHIFT;
      end
      SHIFT: begin
        // A 16th bit arriving with cs_n rising still completes the frame
        if (last_bit) begin
          state_nxt = COMMIT;
        end else if (cs_rise) begin
          frame_error = 1'b1;
          state_nxt   = IDLE;
        end
      end
      COMMIT: begin
        state_nxt = WAIT_CS;
        if (!shift_reg[RW_BIT]) begin
          if (commit_addr_ok) cfg_write_enable = 1'b1;
          else                frame_error      = 1'b1;
        end
      end
      WAIT_CS: begin
        // Level test so a cs_n rise already seen during COMMIT is not lost
        if (cs_n_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath, shadow copy and core-facing write registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_reg    <= '0;
      rd_frame  <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= (i == 0) ? THRESHOLD_RST : 8'h00;
      end
    end else begin
      if ((state == IDLE) && cs_fall) begin
        bit_cnt  <= '0;
        rd_frame <= 1'b0;
      end

      if (shift_evt) begin
        shift_reg <= frame_nxt;
        bit_cnt   <= bit_cnt + 5'd1;
        if ((bit_cnt == 5'd7) && frame_nxt[RW_BIT-HDR_SHIFT]) begin
          rd_frame <= 1'b1;
          tx_reg   <= addr_in_range(hdr_addr, NREGS) ? shadow[hdr_addr] : 8'h00;
        end
      end

      // tx[7] already holds the MSB at bit 8, so shifting starts with bit 9
      if ((state == SHIFT) && sclk_fall && rd_frame &&
          (bit_cnt >= 5'd9) && (bit_cnt <= 5'd15)) begin
        tx_reg <= {tx_reg[6:0], 1'b0};
      end

      // Address/data are registered on the last bit so they are already
      // valid in the COMMIT cycle where the strobe is raised
      if (last_bit && !frame_nxt[RW_BIT] &&
          addr_in_range(frame_nxt[ADDR_MSB:ADDR_LSB], NREGS)) begin
        cfg_addr <= frame_nxt[ADDR_MSB:ADDR_LSB];
        cfg_data <= frame_nxt[DATA_MSB:DATA_LSB];
      end

      if (cfg_write_enable) begin
        shadow[shift_reg[ADDR_MSB:ADDR_LSB]] <= shift_reg[DATA_MSB:DATA_LSB];
      end
    end
  end

  assign busy     = (state == SHIFT) || (state == COMMIT);
  assign spi_miso = (rd_frame && (state == SHIFT) && (bit_cnt[4:3] == 2'b01))
                    ? tx_reg[7] : 1'b0;

endmodule
